spi_flash_ctrl: RTL and testbench

- Read-only word-fetch controller for the on-board EN25F80 SPI NOR flash.
- Sits directly downstream of devctrl, driving the top-level spi_clk / spi_cs_n / spi_di pins and sampling spi_do.
- Converts each 32-bit device read into one READ (0x03) transaction: 8-bit command, 24-bit address, 32 data bits.
- Holds the CPU off through busy_o until the word is assembled.

---
 rtl/spi_flash_ctrl.sv | 166 ++++++++++++++++
 tb/tb_spi_flash_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_ctrl.sv
// Read-only word fetch from an EN25F80 SPI NOR flash: one READ (0x03) transaction
// per 32-bit access, SPI mode 0, little-endian word assembly.
module spi_flash_ctrl #(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned CS_GAP  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        devEnable_i,
  input  logic        readEnable_i,
  input  logic [31:0] addr_i,
  output logic [31:0] readData_o,
  output logic        busy_o,
  output logic        spi_clk_o,
  output logic        spi_cs_n_o,
  output logic        spi_di_o,
  input  logic        spi_do_i
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;
  localparam int unsigned BIT_W = 7;
  localparam logic [7:0]  CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [31:0]       tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic [31:0]       data_q, data_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              di_q, di_d;
  logic              req_c;
  logic [31:0]       tx_load_c;
  logic              unused_addr_c;

  assign req_c         = devEnable_i & readEnable_i;
  assign tx_load_c     = {CMD_READ, addr_i[23:2], 2'b00};
  assign unused_addr_c = ^{addr_i[31:24], addr_i[1:0]};

  assign busy_o     = req_c & (state_q != S_DONE);
  assign readData_o = data_q;
  assign spi_clk_o  = sclk_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_di_o   = di_q;

  // Next-state and next-output logic; output registers hold the value for the state being entered.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    di_d    = di_q;

    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (req_c) begin
          tx_d    = tx_load_c;
          di_d    = tx_load_c[31];
          cs_n_d  = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        bit_d   = '0;
        div_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising edge: flash data is valid for the second 32 bits.
            if (bit_q >= BIT_W'(32)) begin
              rx_d = {rx_q[30:0], spi_do_i};
            end
            bit_d = bit_q + BIT_W'(1);
          end else begin
            // Falling edge: present the next MOSI bit; zeros refill once cmd+addr are out.
            tx_d = {tx_q[30:0], 1'b0};
            di_d = tx_q[30];
            if (bit_q == BIT_W'(64)) begin
              state_d = S_HOLD;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_HOLD: begin
        sclk_d  = 1'b0;
        di_d    = 1'b0;
        data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
        cs_n_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        cs_n_d  = 1'b1;
        gap_d   = GAP_W'(CS_GAP);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase

    // Request withdrawn mid-transaction: release the flash, keep the previous word.
    if (!req_c && (state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD)) begin
      state_d = S_IDLE;
      cs_n_d  = 1'b1;
      sclk_d  = 1'b0;
      di_d    = 1'b0;
      gap_d   = GAP_W'(CS_GAP);
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      di_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      di_q    <= di_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Directed bench for spi_flash_ctrl with a behavioural mode-0 SPI flash responder.
module tb_spi_flash_ctrl;

  logic        clk;
  logic        rst;
  logic        dev_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;

  int total = 0;
  int bad   = 0;

  // Flash model state: 32-bit serial response, first byte in [31:24]
  logic [31:0] rsp_stream;
  logic [31:0] mosi_cap;
  int          rise_cnt;

  spi_flash_ctrl #(.CLK_DIV(1), .CS_GAP(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .devEnable_i  (dev_en),
    .readEnable_i (rd_en),
    .addr_i       (addr),
    .readData_o   (rdata),
    .busy_o       (busy),
    .spi_clk_o    (sclk),
    .spi_cs_n_o   (cs_n),
    .spi_di_o     (mosi),
    .spi_do_i     (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash: capture command/address on rising SCLK, drive data after falling SCLK.
  initial begin
    miso     = 1'b0;
    rise_cnt = 0;
    mosi_cap = '0;
  end

  always @(negedge cs_n) begin
    rise_cnt = 0;
    mosi_cap = '0;
  end

  always @(posedge sclk) begin
    if (!cs_n) begin
      if (rise_cnt < 32) mosi_cap = {mosi_cap[30:0], mosi};
      rise_cnt = rise_cnt + 1;
    end
  end

  always @(negedge sclk) begin
    if (!cs_n && rise_cnt >= 32 && rise_cnt < 64) miso = rsp_stream[31 - (rise_cnt - 32)];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a read and run until busy drops; reports cycles, SCLK rises and CS-high lead-in.
  task automatic run_read(input logic [31:0] a, output int lat, output int rises, output int cs_hi);
    logic prev;
    bit   low_seen;
    addr     = a;
    dev_en   = 1'b1;
    rd_en    = 1'b1;
    lat      = 0;
    rises    = 0;
    cs_hi    = 0;
    low_seen = 1'b0;
    prev     = sclk;
    #1;
    while (busy && lat < 1000) begin
      if (!low_seen && cs_n) cs_hi++;
      else low_seen = 1'b1;
      tick();
      lat++;
      if (lat == 5) addr = ~a;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
  endtask

  initial begin
    int lat, rises, cs_hi, toggles;
    logic prev;
    bit   flag;

    rst        = 1'b1;
    dev_en     = 1'b0;
    rd_en      = 1'b0;
    addr       = '0;
    rsp_stream = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_cs_n", 32'(cs_n), 32'd1);
    chk("reset_sclk", 32'(sclk), 32'd0);
    chk("reset_data", rdata, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Single aligned read
    rsp_stream = 32'hEFBEADDE;
    run_read(32'h0001_2344, lat, rises, cs_hi);
    chk("rd1_latency", 32'(lat), 32'd131);
    chk("rd1_data", rdata, 32'hDEADBEEF);
    chk("rd1_rises", 32'(rises), 32'd64);
    chk("rd1_mosi", mosi_cap, 32'h0301_2344);
    chk("rd1_cs_done", 32'(cs_n), 32'd1);
    dev_en = 1'b0;
    rd_en  = 1'b0;
    tick();
    chk("rd1_idle_busy", 32'(busy), 32'd0);
    chk("rd1_hold_data", rdata, 32'hDEADBEEF);
    repeat (5) tick();

    // Unaligned, high address bits ignored
    rsp_stream = 32'h11223344;
    run_read(32'hBFF0_0007, lat, rises, cs_hi);
    chk("rd2_latency", 32'(lat), 32'd131);
    chk("rd2_mosi", mosi_cap, 32'h03F0_0004);
    chk("rd2_data", rdata, 32'h44332211);

    // Back-to-back: request held through DONE, waits out the CS gap
    rsp_stream = 32'h5AC30F96;
    tick();
    run_read(32'h00AB_CDE8, lat, rises, cs_hi);
    chk("b2b_latency", 32'(lat), 32'd134);
    chk("b2b_cs_gap", 32'(cs_hi), 32'd4);
    chk("b2b_mosi", mosi_cap, 32'h03AB_CDE8);
    chk("b2b_data", rdata, 32'h960FC35A);
    dev_en = 1'b0;
    rd_en  = 1'b0;
    repeat (5) tick();

    // Write access is ignored
    dev_en = 1'b1;
    rd_en  = 1'b0;
    addr   = 32'h0000_0100;
    flag   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (busy || !cs_n) flag = 1'b1;
      tick();
    end
    chk("wr_no_activity", 32'(flag), 32'd0);
    chk("wr_data_kept", rdata, 32'h960FC35A);
    dev_en = 1'b0;
    tick();

    // Abort after 40 SCLK edges, then a full read after the CS gap
    rsp_stream = 32'h0;
    addr       = 32'h0000_0200;
    dev_en     = 1'b1;
    rd_en      = 1'b1;
    toggles    = 0;
    prev       = sclk;
    for (int i = 0; i < 500 && toggles < 40; i++) begin
      tick();
      if (sclk != prev) toggles++;
      prev = sclk;
    end
    chk("abort_edges", 32'(toggles), 32'd40);
    dev_en = 1'b0;
    tick();
    chk("abort_cs_n", 32'(cs_n), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_data", rdata, 32'h960FC35A);
    chk("abort_busy", 32'(busy), 32'd0);
    rsp_stream = 32'h01020304;
    run_read(32'h0000_0010, lat, rises, cs_hi);
    chk("post_abort_latency", 32'(lat), 32'd134);
    chk("post_abort_mosi", mosi_cap, 32'h0300_0010);
    chk("post_abort_data", rdata, 32'h04030201);
    dev_en = 1'b0;
    rd_en  = 1'b0;
    tick();

    // Reset in the middle of SHIFT
    rsp_stream = 32'hFFFFFFFF;
    addr       = 32'h0000_0300;
    dev_en     = 1'b1;
    rd_en      = 1'b1;
    repeat (20) tick();
    chk("pre_rst_cs_low", 32'(cs_n), 32'd0);
    rst = 1'b1;
    tick();
    chk("rst_mid_cs_n", 32'(cs_n), 32'd1);
    chk("rst_mid_sclk", 32'(sclk), 32'd0);
    chk("rst_mid_data", rdata, 32'h0);
    tick();
    rst    = 1'b0;
    dev_en = 1'b0;
    rd_en  = 1'b0;
    tick();
    chk("rst_after_busy", 32'(busy), 32'd0);
    chk("rst_after_cs_n", 32'(cs_n), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
